buffer_drain: RTL and testbench

//  Read-side adapter for the team's buffer (FIFO) block. It drives the buffer's

---
 rtl/buffer_drain.sv | 89 ++++++++
 tb/tb_buffer_drain.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/buffer_drain.sv
// buffer_drain: read-side adapter between the FIFO consume/empty/data_out
// port and a valid/ready stream. The FIFO answers one cycle after a consume,
// so a 2-entry skid store absorbs that latency. It sustains one word per
// cycle and never overreads the FIFO.
module buffer_drain #(
    parameter int bit_width = 16,
    parameter int cnt_w     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 buf_empty,
    input  logic [bit_width-1:0] buf_data,
    output logic                 buf_consume,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [bit_width-1:0] out_data,
    output logic [cnt_w-1:0]     word_count
);

    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} occ_t;

    occ_t                 occ, occ_next;
    logic                 inflight;
    logic                 rd_ptr;
    logic                 wr_ptr;
    logic                 pop;
    logic [1:0]           pending;
    logic [bit_width-1:0] store [2];

    // Stream side, consume decision and next-occupancy.
    always_comb begin
        out_valid = (occ != EMPTY) && !flush && !rst;
        out_data  = store[rd_ptr];
        pop       = out_valid && out_ready;
        // Words we will hold after this edge. The FIFO only answers one
        // cycle later, so a read in flight already uses up a slot.
        pending     = 2'(occ) + 2'(inflight) - 2'(pop);
        buf_consume = !rst && !flush && !buf_empty && (pending < 2'd2);
        // Next free slot in the circular store.
        wr_ptr      = rd_ptr ^ occ[0];
        occ_next    = occ;
        if (flush) begin
            occ_next = EMPTY;
        end else begin
            case (pending)
                2'd0:    occ_next = EMPTY;
                2'd1:    occ_next = ONE;
                default: occ_next = TWO;
            endcase
        end
    end

    // Occupancy state register.
    always_ff @(posedge clk) begin
        if (rst) occ <= EMPTY;
        else     occ <= occ_next;
    end

    // In-flight flag, read pointer and delivered-word counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight   <= 1'b0;
            rd_ptr     <= 1'b0;
            word_count <= '0;
        end else if (flush) begin
            inflight <= 1'b0;
            rd_ptr   <= 1'b0;
        end else begin
            inflight <= buf_consume;
            if (pop) begin
                rd_ptr     <= ~rd_ptr;
                word_count <= word_count + cnt_w'(1);
            end
        end
    end

    // Capture the FIFO answer. When the store is full and the head pops in
    // the same cycle, wr_ptr equals rd_ptr. That is safe because the head
    // is read combinationally before the edge.
    always_ff @(posedge clk) begin
        if (!rst && !flush && inflight) store[wr_ptr] <= buf_data;
    end

    // A capture into a full store with no pop would overwrite a live word.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(inflight && !flush && occ == TWO && !pop));

endmodule

// File: tb/tb_buffer_drain.sv
// tb_buffer_drain: FIFO model with one-cycle read latency in front of
// buffer_drain. A scoreboard queue holds words in write order.
// A second instance with cnt_w=4 shares all inputs and is used for counter wrap.
module tb_buffer_drain;

    logic        clk = 1'b0;
    logic        rst, flush, out_ready;
    logic        buf_empty = 1'b1;
    logic [15:0] buf_data = '0;
    logic        buf_consume, out_valid;
    logic [15:0] out_data, word_count;
    logic        buf_consume4, out_valid4;
    logic [15:0] out_data4;
    logic [3:0]  word_count4;

    logic        wr_en;
    logic [15:0] wr_data;
    logic [15:0] bufq[$];
    logic [15:0] exp_q[$];
    bit          overread = 1'b0;

    int checks = 0;
    int errors = 0;
    int exp_wc = 0;

    typedef struct {
        logic [15:0] base;
        int          n;
        bit          preload;
        int          stall;
    } vec_t;

    always #5 clk = ~clk;

    buffer_drain #(.bit_width(16), .cnt_w(16)) dut (
        .clk(clk), .rst(rst), .buf_empty(buf_empty), .buf_data(buf_data),
        .buf_consume(buf_consume), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .word_count(word_count));

    buffer_drain #(.bit_width(16), .cnt_w(4)) dut4 (
        .clk(clk), .rst(rst), .buf_empty(buf_empty), .buf_data(buf_data),
        .buf_consume(buf_consume4), .flush(flush), .out_valid(out_valid4),
        .out_ready(out_ready), .out_data(out_data4), .word_count(word_count4));

    // FIFO model: data_out is valid the cycle after consume is sampled.
    always @(posedge clk) begin
        if (buf_consume) begin
            if (bufq.size() == 0) overread <= 1'b1;
            else buf_data <= bufq.pop_front();
        end
        if (wr_en) bufq.push_back(wr_data);
        buf_empty <= (bufq.size() == 0);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard and cycle-level protocol checks, sampled on the falling edge.
    logic        prev_hold = 1'b0;
    logic [15:0] prev_data = '0;
    always @(negedge clk) begin
        if (!rst) begin
            if (!flush && out_valid && out_ready) begin
                if (exp_q.size() == 0) chk("unexpected_word", {16'h0, out_data}, 32'hFFFF_FFFF);
                else chk("sb_data", {16'h0, out_data}, {16'h0, exp_q.pop_front()});
            end
            if (buf_empty) chk("consume_when_empty", {31'h0, buf_consume}, 32'h0);
            if (prev_hold && !flush) begin
                chk("stall_valid", {31'h0, out_valid}, 32'h1);
                chk("stall_data", {16'h0, out_data}, {16'h0, prev_data});
            end
            chk("w4_consume", {31'h0, buf_consume4}, {31'h0, buf_consume});
            chk("w4_valid", {31'h0, out_valid4}, {31'h0, out_valid});
            if (out_valid) chk("w4_data", {16'h0, out_data4}, {16'h0, out_data});
        end
        prev_hold = !rst && !flush && out_valid && !out_ready;
        prev_data = out_data;
    end

    task automatic run_vec(input vec_t v);
        int pops = 0, ncons = 0, stall_cons = 0;
        int first_cons = -1, last_cons = -1, first_pop = -1, last_pop = -1;
        if (v.preload) begin
            flush = 1'b1;
            for (int i = 0; i < v.n; i++) begin
                wr_en = 1'b1;
                wr_data = v.base + 16'(i);
                exp_q.push_back(wr_data);
                tick();
            end
            wr_en = 1'b0;
            tick();
            flush = 1'b0;
        end
        for (int cyc = 0; cyc < 300 && pops < v.n; cyc++) begin
            out_ready = (cyc >= v.stall);
            if (!v.preload && (cyc % 2 == 0) && (cyc / 2 < v.n)) begin
                wr_en = 1'b1;
                wr_data = v.base + 16'(cyc / 2);
                exp_q.push_back(wr_data);
            end else begin
                wr_en = 1'b0;
            end
            #1;
            if (buf_consume) begin
                ncons++;
                if (first_cons < 0) first_cons = cyc;
                last_cons = cyc;
                if (cyc < v.stall) stall_cons++;
            end
            if (out_valid && out_ready) begin
                pops++;
                if (first_pop < 0) first_pop = cyc;
                last_pop = cyc;
            end
            if (v.stall > 0 && cyc == v.stall - 1) begin
                chk("stall_consumes", stall_cons, 2);
                chk("stall_head", {16'h0, out_data}, {16'h0, v.base});
            end
            tick();
        end
        wr_en = 1'b0;
        chk("words_delivered", pops, v.n);
        exp_wc += v.n;
        chk("word_count", {16'h0, word_count}, exp_wc & 32'hFFFF);
        chk("sb_drained", exp_q.size(), 0);
        if (v.preload && v.stall == 0) begin
            chk("consume_run", last_cons - first_cons + 1, v.n);
            chk("consume_total", ncons, v.n);
            chk("first_latency", first_pop - first_cons, 2);
            chk("no_bubbles", last_pop - first_pop + 1, v.n);
        end
    endtask

    vec_t vecs[4];

    initial begin
        int pops;
        int wc_before;
        logic p;
        vecs[0] = '{base: 16'h0001, n: 6, preload: 1'b1, stall: 0};
        vecs[1] = '{base: 16'h000A, n: 6, preload: 1'b1, stall: 8};
        vecs[2] = '{base: 16'h0010, n: 4, preload: 1'b0, stall: 0};
        vecs[3] = '{base: 16'hFFF0, n: 5, preload: 1'b1, stall: 3};

        rst = 1'b1; flush = 1'b0; out_ready = 1'b0; wr_en = 1'b0; wr_data = '0;

        // Reset held while the FIFO is preloaded with 17 words.
        for (int i = 0; i < 17; i++) begin
            wr_en = 1'b1;
            wr_data = 16'h0200 + 16'(i);
            exp_q.push_back(wr_data);
            tick();
            #1;
            if (i < 3) begin
                chk("rst_valid", {31'h0, out_valid}, 32'h0);
                chk("rst_consume", {31'h0, buf_consume}, 32'h0);
                chk("rst_count", {16'h0, word_count}, 32'h0);
            end
        end
        wr_en = 1'b0;
        rst = 1'b0;

        // Stream 17 words and watch the 4-bit counter wrap.
        out_ready = 1'b1;
        pops = 0;
        for (int cyc = 0; cyc < 100 && pops < 17; cyc++) begin
            #1;
            p = out_valid && out_ready;
            tick();
            if (p) begin
                pops++;
                if (pops == 16) chk("wrap_after_16", {28'h0, word_count4}, 32'h0);
                if (pops == 17) chk("wrap_after_17", {28'h0, word_count4}, 32'h1);
            end
        end
        chk("wrap_words", pops, 17);
        exp_wc = 17;
        chk("wrap_count16", {16'h0, word_count}, 32'd17);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Flush while one word is stored and a second read is in flight.
        flush = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1;
            wr_data = 16'h0020 + 16'(i);
            exp_q.push_back(wr_data);
            tick();
        end
        wr_en = 1'b0;
        tick();
        flush = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        #1;
        chk("preflush_valid", {31'h0, out_valid}, 32'h1);
        chk("preflush_consume", {31'h0, buf_consume}, 32'h0);
        wc_before = exp_wc;
        flush = 1'b1;
        #1;
        chk("flush_consume", {31'h0, buf_consume}, 32'h0);
        chk("flush_valid", {31'h0, out_valid}, 32'h0);
        void'(exp_q.pop_front());
        void'(exp_q.pop_front());
        tick();
        flush = 1'b0;
        #1;
        chk("postflush_valid", {31'h0, out_valid}, 32'h0);
        chk("postflush_count", {16'h0, word_count}, wc_before & 32'hFFFF);
        out_ready = 1'b1;
        pops = 0;
        for (int cyc = 0; cyc < 100 && pops < 6; cyc++) begin
            #1;
            if (out_valid && out_ready) pops++;
            tick();
        end
        chk("flush_resume_words", pops, 6);
        exp_wc += 6;
        chk("flush_word_count", {16'h0, word_count}, exp_wc & 32'hFFFF);
        chk("flush_sb_drained", exp_q.size(), 0);

        tick();
        chk("no_overread", {31'h0, overread}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
